// File: rtl/rv32im_wb_ram_if.sv
// Wishbone classic-cycle bus between the rv32im memory-stage master and the
// RAM slave. Signal names are slave-relative (_i driven by the master, _o
// driven by the slave) so that they match the slave's port list one-to-one.
interface rv32im_wb_ram_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) ();

  logic                cyc_i;
  logic                stb_i;
  logic                we_i;
  logic [ADDR_W-1:0]   adr_i;
  logic [XLEN-1:0]     dat_i;
  logic [XLEN/8-1:0]   sel_i;
  logic [XLEN-1:0]     dat_o;
  logic                ack_o;
  logic                err_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o, err_o
  );

endinterface

// File: rtl/rv32im_wb_ram.sv
// rv32im_wb_ram: Wishbone classic-cycle slave in front of a synchronous,
// word-wide RAM with byte-lane write enables. Each accepted request is
// answered by a single-cycle ack_o (or err_o) after WAIT_STATES extra cycles.
//
// Build option: define WB_RAM_BOUNDS_CHECK_EN to answer addresses >= DEPTH
// with err_o (no write, dat_o untouched). Without it the address wraps
// modulo DEPTH and err_o is tied low.
module rv32im_wb_ram #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rv32im_wb_ram_if.slave bus
);

  localparam int SEL_W = XLEN / 8;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [XLEN-1:0]     dat_q;
  logic [SEL_W-1:0]    sel_q;
  logic                ack_q;
  logic [XLEN-1:0]     rdat_q;

  logic [XLEN-1:0]     mem_q [DEPTH];

  logic                req;
  logic                go_resp;
  logic                cur_we;
  logic [ADDR_W-1:0]   cur_adr;
  logic [XLEN-1:0]     cur_dat;
  logic [SEL_W-1:0]    cur_sel;
  logic [IDX_W-1:0]    cur_idx;
  logic                cur_ok;
  logic                wr_en;

  assign req = bus.cyc_i & bus.stb_i;

  // Request fields that apply to the transfer completing this edge: live
  // inputs when answering straight from IDLE, latched copies otherwise.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    cur_we  = we_q;
    cur_adr = adr_q;
    cur_dat = dat_q;
    cur_sel = sel_q;
    if (state_q == ST_IDLE) begin
      cur_we  = bus.we_i;
      cur_adr = bus.adr_i;
      cur_dat = bus.dat_i;
      cur_sel = bus.sel_i;
    end
  end

  // High on the edge that moves the FSM into RESP (write commit / read fetch).
  always_comb begin
    go_resp = 1'b0;
    case (state_q)
      ST_IDLE: go_resp = req && (WAIT_STATES == 0);
      ST_WAIT: go_resp = bus.cyc_i && (cnt_q == 4'd1);
      default: go_resp = 1'b0;
    endcase
  end

  assign cur_idx = cur_adr[IDX_W-1:0];

`ifdef WB_RAM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic err_q;

  assign cur_ok    = ({1'b0, cur_adr} < DEPTH_LIM);
  assign bus.err_o = err_q;
`else
  // Address wraps modulo DEPTH; the upper address bits are intentionally
  // ignored and only folded here so they count as read.
  logic unused_adr_bits;

  assign unused_adr_bits = ^cur_adr;
  assign cur_ok          = 1'b1;
  assign bus.err_o       = 1'b0;
`endif

  // Reset gates the commit so an edge coinciding with reset never writes.
  assign wr_en = go_resp & cur_we & cur_ok & ~rst_i;

  // Bus FSM: accepts a request, counts wait states, emits one response pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
`ifdef WB_RAM_BOUNDS_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop in
      // this block updates from pre-edge values, independent of statement order.
      ack_q <= 1'b0;
`ifdef WB_RAM_BOUNDS_CHECK_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            we_q    <= bus.we_i;
            adr_q   <= bus.adr_i;
            dat_q   <= bus.dat_i;
            sel_q   <= bus.sel_i;
            cnt_q   <= 4'(WAIT_STATES);
            state_q <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!bus.cyc_i) begin
            // Master abandoned the cycle: no response, nothing written.
            cnt_q   <= 4'd0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          // stb_i is still high here on the ack edge; it is deliberately ignored.
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (go_resp) begin
        ack_q <= cur_ok;
`ifdef WB_RAM_BOUNDS_CHECK_EN
        err_q <= ~cur_ok;
`endif
        if (!cur_we && cur_ok) begin
          rdat_q <= mem_q[cur_idx];
        end
      end
    end
  end

  // RAM write port with per-byte-lane enables.
  always_ff @(posedge clk_i) begin
    // NOTE: the RAM array has no reset; its contents survive rst_i and are
    // only changed by committed writes.
    if (wr_en) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (cur_sel[i]) begin
          mem_q[cur_idx][8*i +: 8] <= cur_dat[8*i +: 8];
        end
      end
    end
  end

  assign bus.ack_o = ack_q;
  assign bus.dat_o = rdat_q;

endmodule
